// File: rtl/cont_mem_pkg.sv
// rtl/cont_mem_pkg.sv - shared types and sizing helpers for the class prototype memory
//
// Purpose: FSM state type plus small sizing functions used by cont_mem_acc and
//          cont_mem_chunk_upd. No ports.
package cont_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } cm_state_t;

  // Symmetric saturation limit of a signed counter of width cnt_w.
  function automatic int cnt_max(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  // Number of chunks (cycles) needed to sweep one hypervector.
  function automatic int nch(input int dimensions, input int chunk);
    return dimensions / chunk;
  endfunction

  // Width of the label port: max(1, clog2(num_classes)).
  function automatic int label_w(input int num_classes);
    return (num_classes > 1) ? $clog2(num_classes) : 1;
  endfunction

  // Width of the chunk index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cont_mem_chunk_upd.sv
// rtl/cont_mem_chunk_upd.sv - combinational update of one chunk of class counters
//
// Purpose: applies one chunk of a sample to CHUNK saturating signed counters and
//          derives the new prototype bits (tie keeps the current bit).
// Ports:
//   bits      in  CHUNK        sample bits of this chunk
//   cnt_cur   in  CHUNK*CNT_W  current counters, counter i at [i*CNT_W +: CNT_W]
//   proto_cur in  CHUNK        current prototype bits
//   cnt_nxt   out CHUNK*CNT_W  updated counters
//   proto_nxt out CHUNK        updated prototype bits
//   sat_hit   out 1            some counter was held at its limit
//                              (only with CONT_MEM_SAT_STATUS_EN)
module cont_mem_chunk_upd
  import cont_mem_pkg::*;
#(
  parameter int CHUNK = 100,
  parameter int CNT_W = 8
) (
  input  logic [CHUNK-1:0]       bits,
  input  logic [CHUNK*CNT_W-1:0] cnt_cur,
  input  logic [CHUNK-1:0]       proto_cur,
  output logic [CHUNK*CNT_W-1:0] cnt_nxt,
  output logic [CHUNK-1:0]       proto_nxt
`ifdef CONT_MEM_SAT_STATUS_EN
  ,
  output logic                   sat_hit
`endif
);

  localparam logic signed [CNT_W-1:0] LIM_P = CNT_W'(cnt_max(CNT_W));
  localparam logic signed [CNT_W-1:0] LIM_N = CNT_W'(-cnt_max(CNT_W));
  localparam logic signed [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic signed [CNT_W-1:0] ZERO  = '0;

  logic signed [CNT_W-1:0] cur;
  logic signed [CNT_W-1:0] nxt;

  always_comb begin
    cnt_nxt   = cnt_cur;
    proto_nxt = proto_cur;
    cur       = '0;
    nxt       = '0;
`ifdef CONT_MEM_SAT_STATUS_EN
    sat_hit   = 1'b0;
`endif
    for (int i = 0; i < CHUNK; i++) begin
      cur = $signed(cnt_cur[i*CNT_W +: CNT_W]);
      if (bits[i]) begin
        if (cur == LIM_P) begin
          nxt = cur;
`ifdef CONT_MEM_SAT_STATUS_EN
          sat_hit = 1'b1;
`endif
        end else begin
          nxt = cur + ONE;
        end
      end else begin
        if (cur == LIM_N) begin
          nxt = cur;
`ifdef CONT_MEM_SAT_STATUS_EN
          sat_hit = 1'b1;
`endif
        end else begin
          nxt = cur - ONE;
        end
      end
      cnt_nxt[i*CNT_W +: CNT_W] = nxt;
      // Zero is a tie: the prototype keeps whatever it already had.
      if (nxt > ZERO) begin
        proto_nxt[i] = 1'b1;
      end else if (nxt < ZERO) begin
        proto_nxt[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cont_mem_acc.sv
// rtl/cont_mem_acc.sv - multi-class running-majority associative memory
//
// Purpose: keeps one saturating signed counter per dimension per class and a
//          prototype bit per dimension per class; labelled samples are folded in
//          CHUNK dimensions per cycle.
// Optional: CONT_MEM_SAT_STATUS_EN adds sticky per-class saturation flags.
// Ports:
//   clk       in  1                       clock
//   nrst      in  1                       async active-low reset
//   in_valid  in  1                       hv/label valid
//   in_ready  out 1                       idle and not clearing
//   hv        in  DIMENSIONS              sample hypervector
//   label     in  label_w(NUM_CLASSES)    target class
//   clear     in  1                       zero counters, restore start prototypes
//   busy      out 1                       FSM not idle
//   done      out 1                       one-cycle pulse after last chunk
//   proto_hv  out NUM_CLASSES*DIMENSIONS  class c at [c*DIMENSIONS +: DIMENSIONS]
//   sat_flag  out NUM_CLASSES             sticky clamp flags (optional)
module cont_mem_acc
  import cont_mem_pkg::*;
#(
  parameter int                     DIMENSIONS  = 10000,
  parameter int                     NUM_CLASSES = 2,
  parameter int                     CNT_W       = 8,
  parameter int                     CHUNK       = 100,
  parameter logic [NUM_CLASSES-1:0] START_ONES  = 2'b10
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DIMENSIONS-1:0]             hv,
  input  logic [label_w(NUM_CLASSES)-1:0]   label,
  input  logic                              clear,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_CLASSES*DIMENSIONS-1:0] proto_hv
`ifdef CONT_MEM_SAT_STATUS_EN
  ,
  output logic [NUM_CLASSES-1:0]            sat_flag
`endif
);

  localparam int NCH     = nch(DIMENSIONS, CHUNK);
  localparam int IDX_W   = idx_w(NCH);
  localparam int LBL_W   = label_w(NUM_CLASSES);
  localparam int SLICE_W = CHUNK * CNT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  cm_state_t                       state;
  logic [IDX_W-1:0]                idx;
  logic [NCH-1:0][CHUNK-1:0]       hv_buf;
  logic [LBL_W-1:0]                lbl_buf;
  logic [NCH-1:0][SLICE_W-1:0]     cnt_q   [NUM_CLASSES];
  logic [NCH-1:0][CHUNK-1:0]       proto_q [NUM_CLASSES];

  logic                            lbl_ok;
  logic [LBL_W-1:0]                sel;
  logic [SLICE_W-1:0]              cnt_cur;
  logic [SLICE_W-1:0]              cnt_nxt;
  logic [CHUNK-1:0]                proto_cur;
  logic [CHUNK-1:0]                proto_nxt;
  logic [CHUNK-1:0]                bits_cur;

  assign in_ready = (state == ST_IDLE) && !clear;
  assign busy     = (state != ST_IDLE);

  // An out-of-range label still runs the full sequence but never writes.
  // sel is forced in range so the read mux never indexes past the array.
  assign lbl_ok = (int'(lbl_buf) < NUM_CLASSES);
  assign sel    = lbl_ok ? lbl_buf : '0;

  assign cnt_cur   = cnt_q[sel][idx];
  assign proto_cur = proto_q[sel][idx];
  assign bits_cur  = hv_buf[idx];

`ifdef CONT_MEM_SAT_STATUS_EN
  logic sat_hit;
`endif

  cont_mem_chunk_upd #(
    .CHUNK (CHUNK),
    .CNT_W (CNT_W)
  ) u_chunk_upd (
    .bits      (bits_cur),
    .cnt_cur   (cnt_cur),
    .proto_cur (proto_cur),
    .cnt_nxt   (cnt_nxt),
    .proto_nxt (proto_nxt)
`ifdef CONT_MEM_SAT_STATUS_EN
    ,
    .sat_hit   (sat_hit)
`endif
  );

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_proto_out
    assign proto_hv[c*DIMENSIONS +: DIMENSIONS] = proto_q[c];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      done    <= 1'b0;
      hv_buf  <= '0;
      lbl_buf <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        cnt_q[c]   <= '0;
        proto_q[c] <= {DIMENSIONS{START_ONES[c]}};
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
              cnt_q[c]   <= '0;
              proto_q[c] <= {DIMENSIONS{START_ONES[c]}};
            end
          end else if (in_valid) begin
            hv_buf  <= hv;
            lbl_buf <= label;
            idx     <= '0;
            state   <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (lbl_ok) begin
            cnt_q[sel][idx]   <= cnt_nxt;
            proto_q[sel][idx] <= proto_nxt;
          end
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CONT_MEM_SAT_STATUS_EN
  // Set on the same edge that performs the clamped write, so it is visible in
  // the cycle after the clamp.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sat_flag <= '0;
    end else if (state == ST_IDLE && clear) begin
      sat_flag <= '0;
    end else if (state == ST_ACCUM && lbl_ok && sat_hit) begin
      sat_flag[sel] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cont_mem_acc.sv
// tb/tb_cont_mem_acc.sv - randomized self-checking bench for cont_mem_acc
module tb_cont_mem_acc;

  localparam int D   = 16;
  localparam int C   = 4;
  localparam int NC  = 2;
  localparam int W   = 3;
  localparam int NCH = D / C;
  localparam int LIM = 3;

  logic          clk      = 1'b0;
  logic          nrst     = 1'b0;
  logic          in_valid = 1'b0;
  logic          clear    = 1'b0;
  logic [D-1:0]  hv       = '0;
  logic [0:0]    label    = '0;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic [NC*D-1:0] proto_hv;
`ifdef CONT_MEM_SAT_STATUS_EN
  logic [NC-1:0] sat_flag;
`endif

  cont_mem_acc #(
    .DIMENSIONS (D),
    .NUM_CLASSES(NC),
    .CNT_W      (W),
    .CHUNK      (C),
    .START_ONES (2'b10)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .hv       (hv),
    .label    (label),
    .clear    (clear),
    .busy     (busy),
    .done     (done),
    .proto_hv (proto_hv)
`ifdef CONT_MEM_SAT_STATUS_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  // Three-class instance for the out-of-range label case.
  logic          b_valid = 1'b0;
  logic [D-1:0]  b_hv    = '0;
  logic [1:0]    b_label = '0;
  logic          b_ready;
  logic          b_busy;
  logic          b_done;
  logic [3*D-1:0] b_proto;
`ifdef CONT_MEM_SAT_STATUS_EN
  logic [2:0]    b_sat;
`endif

  cont_mem_acc #(
    .DIMENSIONS (D),
    .NUM_CLASSES(3),
    .CNT_W      (W),
    .CHUNK      (C),
    .START_ONES (3'b010)
  ) dut_b (
    .clk      (clk),
    .nrst     (nrst),
    .in_valid (b_valid),
    .in_ready (b_ready),
    .hv       (b_hv),
    .label    (b_label),
    .clear    (1'b0),
    .busy     (b_busy),
    .done     (b_done),
    .proto_hv (b_proto)
`ifdef CONT_MEM_SAT_STATUS_EN
    ,
    .sat_flag (b_sat)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: whole-sample majority counters per class.
  int            m_cnt   [NC][D];
  logic [D-1:0]  m_proto [NC];
  logic [NC-1:0] m_sat;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < D; i++) m_cnt[c][i] = 0;
    end
    m_proto[0] = 16'h0000;
    m_proto[1] = 16'hFFFF;
    m_sat      = '0;
  endtask

  task automatic model_apply(input logic [D-1:0] v, input int l);
    if (l >= NC) return;
    for (int i = 0; i < D; i++) begin
      if (v[i]) begin
        if (m_cnt[l][i] == LIM) m_sat[l] = 1'b1;
        else m_cnt[l][i] = m_cnt[l][i] + 1;
      end else begin
        if (m_cnt[l][i] == -LIM) m_sat[l] = 1'b1;
        else m_cnt[l][i] = m_cnt[l][i] - 1;
      end
      if (m_cnt[l][i] > 0) m_proto[l][i] = 1'b1;
      else if (m_cnt[l][i] < 0) m_proto[l][i] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    expect_eq({tag, "_proto0"}, 64'(proto_hv[0 +: D]), 64'(m_proto[0]));
    expect_eq({tag, "_proto1"}, 64'(proto_hv[D +: D]), 64'(m_proto[1]));
`ifdef CONT_MEM_SAT_STATUS_EN
    expect_eq({tag, "_sat"}, 64'(sat_flag), 64'(m_sat));
`endif
  endtask

  task automatic send(input logic [D-1:0] v, input logic [0:0] l, input bit mid_clear);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    expect_eq("ready_before_accept", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    hv       = v;
    label    = l;
    step();
    in_valid = 1'b0;
    hv       = D'($urandom);
    label    = 1'($urandom);
    expect_eq("busy_after_accept", 64'(busy), 64'(1));
    for (int k = 1; k <= NCH; k++) begin
      if (mid_clear && k == 2) clear = 1'b1;
      step();
      clear = 1'b0;
      expect_eq("ready_low_busy", 64'(in_ready), 64'(0));
      expect_eq("done_timing", 64'(done), 64'(k == NCH));
    end
    model_apply(v, int'(l));
    check_all("sample");
    step();
    expect_eq("done_one_cycle", 64'(done), 64'(0));
    expect_eq("idle_again", 64'(busy), 64'(0));
  endtask

  task automatic clear_idle();
    clear = 1'b1;
    #1;
    expect_eq("ready_low_on_clear", 64'(in_ready), 64'(0));
    step();
    clear = 1'b0;
    model_reset();
    check_all("clear");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    step();
    step();
    nrst = 1'b1;
    step();

    // Reset state
    expect_eq("rst_proto0", 64'(proto_hv[0 +: D]), 64'(16'h0000));
    expect_eq("rst_proto1", 64'(proto_hv[D +: D]), 64'(16'hFFFF));
    expect_eq("rst_ready", 64'(in_ready), 64'(1));
    expect_eq("rst_busy", 64'(busy), 64'(0));
    expect_eq("rst_done", 64'(done), 64'(0));
`ifdef CONT_MEM_SAT_STATUS_EN
    expect_eq("rst_sat", 64'(sat_flag), 64'(0));
`endif

    // Basic majority and tie behaviour on class 0
    send(16'hFFFF, 1'b0, 1'b0);
    expect_eq("c0_all_ones", 64'(proto_hv[0 +: D]), 64'(16'hFFFF));
    expect_eq("c1_untouched", 64'(proto_hv[D +: D]), 64'(16'hFFFF));
    send(16'h0000, 1'b0, 1'b0);
    expect_eq("c0_tie_holds", 64'(proto_hv[0 +: D]), 64'(16'hFFFF));
    send(16'h00F0, 1'b0, 1'b0);
    expect_eq("c0_00f0", 64'(proto_hv[0 +: D]), 64'(16'h00F0));

    // Saturation on class 1
    for (int n = 0; n < 5; n++) begin
      send(16'hFFFF, 1'b1, 1'b0);
`ifdef CONT_MEM_SAT_STATUS_EN
      if (n == 3) expect_eq("sat_after_4th", 64'(sat_flag), 64'(2'b10));
`endif
    end
    for (int n = 0; n < 3; n++) send(16'h0000, 1'b1, 1'b0);
    expect_eq("c1_held_at_zero", 64'(proto_hv[D +: D]), 64'(16'hFFFF));
    send(16'h0000, 1'b1, 1'b0);
    expect_eq("c1_flipped", 64'(proto_hv[D +: D]), 64'(16'h0000));

    // clear together with in_valid: no accept, start pattern restored
    in_valid = 1'b1;
    hv       = 16'hFFFF;
    label    = 1'b0;
    clear_idle();
    in_valid = 1'b0;
    expect_eq("clear_no_accept", 64'(busy), 64'(0));
    expect_eq("clear_proto0", 64'(proto_hv[0 +: D]), 64'(16'h0000));
    expect_eq("clear_proto1", 64'(proto_hv[D +: D]), 64'(16'hFFFF));

    // clear while busy is ignored
    send(D'($urandom), 1'b0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) clear_idle();
      else send(D'($urandom), 1'($urandom), bit'($urandom_range(0, 5) == 0));
    end

    // Reset in the middle of a sample
    in_valid = 1'b1;
    hv       = D'($urandom);
    label    = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    nrst = 1'b0;
    #1;
    model_reset();
    expect_eq("midrst_busy", 64'(busy), 64'(0));
    expect_eq("midrst_done", 64'(done), 64'(0));
    check_all("midrst");
    step();
    nrst = 1'b1;
    step();
    send(D'($urandom), 1'b1, 1'b0);

    // Three-class instance: out-of-range label writes nothing
    expect_eq("b_ready", 64'(b_ready), 64'(1));
    b_valid = 1'b1;
    b_hv    = D'($urandom);
    b_label = 2'd3;
    step();
    b_valid = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      step();
      expect_eq("b_done_timing", 64'(b_done), 64'(k == NCH));
    end
    expect_eq("b_oor_protos", 64'(b_proto), 64'(48'h0000_FFFF_0000));
    step();
    expect_eq("b_idle", 64'(b_busy), 64'(0));
    b_valid = 1'b1;
    b_hv    = 16'hFFFF;
    b_label = 2'd2;
    step();
    b_valid = 1'b0;
    for (int k = 0; k < NCH + 1; k++) step();
    expect_eq("b_class2_write", 64'(b_proto), 64'(48'hFFFF_FFFF_0000));
`ifdef CONT_MEM_SAT_STATUS_EN
    expect_eq("b_sat", 64'(b_sat), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
